// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module : fetch_unit_pkg
// Brief  : Shared types and constants for the instruction fetch stage.
// Rev    : 1.0  initial release
// ============================================================================
package fetch_unit_pkg;

    localparam logic [31:0] c_NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        F_IDLE    = 2'd0,
        F_WAIT    = 2'd1,
        F_DISCARD = 2'd2,
        F_FAULT   = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault;
    } fetch_entry_t;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module : fetch_buffer
// Brief  : Prefetch FIFO of {instr, pc, fault} with flush and registered head.
// Rev    : 1.0  initial release
// ============================================================================
module fetch_buffer
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  fetch_entry_t           push_entry_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic                   head_valid_o,
    output fetch_entry_t           head_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;

    fetch_entry_t    mem_q [DEPTH];
    logic [c_AW-1:0] rd_ptr_q;
    logic [c_AW-1:0] wr_ptr_q;
    logic [c_CW-1:0] count_q;
    logic            w_pop;
    logic            w_push;

    assign w_pop  = pop_i & (count_q != '0);
    assign w_push = push_i & ((count_q != c_CW'(DEPTH)) | w_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            // A flush may carry one new entry (the fault marker), landing in slot 0.
            rd_ptr_q <= '0;
            wr_ptr_q <= push_i ? c_AW'(1) : '0;
            count_q  <= push_i ? c_CW'(1) : '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + c_AW'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + c_AW'(1);
            end
            count_q <= count_q + c_CW'(w_push) - c_CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (flush_i && push_i) begin
            mem_q[0] <= push_entry_i;
        end else if (w_push && !flush_i) begin
            mem_q[wr_ptr_q] <= push_entry_i;
        end
    end

    assign head_valid_o = (count_q != '0);
    assign head_o       = mem_q[rd_ptr_q];
    assign count_o      = count_q;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module : fetch_unit
// Brief  : Instruction fetch stage: PC, req/ack memory port, prefetch buffer.
// Rev    : 1.0  initial release
// ============================================================================
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_stall,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic        o_valid,
    output logic        o_fetch_fault
);

    localparam int c_CW = $clog2(BUF_DEPTH) + 1;

    fetch_state_e    state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     req_addr_q, req_addr_d;
    logic            pend_q, pend_d;

    logic            w_ack;
    logic            w_credit;
    logic            w_issue;
    logic            w_push;
    logic            w_pop;
    logic            w_flush;
    logic            w_head_valid;
    fetch_entry_t    w_push_entry;
    fetch_entry_t    w_head;
    logic [c_CW-1:0] w_count;

    // pend_q tracks the memory-side request independently of whether its data is wanted.
    assign w_ack    = i_imem_ack & pend_q;
    assign w_credit = (w_count + c_CW'(pend_q)) < c_CW'(BUF_DEPTH);
    assign w_issue  = rst_n & (state_q == F_IDLE) & ~pend_q & w_credit & ~i_redirect;

    assign o_imem_req  = pend_q | w_issue;
    assign o_imem_addr = pend_q ? req_addr_q : fetch_pc_q;

    assign w_pop   = w_head_valid & ~i_stall & ~i_redirect;
    assign w_flush = i_redirect;

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        req_addr_d   = req_addr_q;
        pend_d       = pend_q;
        w_push       = 1'b0;
        w_push_entry = '{instr: i_imem_rdata, pc: fetch_pc_q, fault: 1'b0};

        if (w_ack) begin
            pend_d = 1'b0;
        end
        if (w_issue) begin
            pend_d     = 1'b1;
            req_addr_d = fetch_pc_q;
        end

        case (state_q)
            F_IDLE: begin
                if (w_issue) begin
                    state_d = F_WAIT;
                end
            end
            F_WAIT: begin
                if (w_ack) begin
                    w_push     = 1'b1;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = F_IDLE;
                end
            end
            F_DISCARD: begin
                if (w_ack) begin
                    state_d = F_IDLE;
                end
            end
            default: begin
                state_d = F_FAULT;
            end
        endcase

        if (i_redirect) begin
            fetch_pc_d = i_redirect_pc;
            if (is_misaligned(i_redirect_pc)) begin
                w_push       = 1'b1;
                w_push_entry = '{instr: c_NOP_INSTR, pc: i_redirect_pc, fault: 1'b1};
                state_d      = F_FAULT;
            end else begin
                w_push  = 1'b0;
                state_d = (pend_q && !w_ack) ? F_DISCARD : F_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= F_IDLE;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            pend_q     <= pend_d;
        end
    end

    fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_buffer (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (w_push),
        .push_entry_i (w_push_entry),
        .pop_i        (w_pop),
        .flush_i      (w_flush),
        .head_valid_o (w_head_valid),
        .head_o       (w_head),
        .count_o      (w_count)
    );

    assign o_valid       = w_head_valid;
    assign o_instr       = w_head_valid ? w_head.instr : c_NOP_INSTR;
    assign o_pc          = w_head_valid ? w_head.pc : 32'h0;
    assign o_fetch_fault = w_head_valid & w_head.fault;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_fetch_unit
// Brief  : Scoreboard bench for fetch_unit with a variable-latency memory model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [31:0] c_KEY    = 32'hA5A5_0000;
    localparam logic [31:0] c_NO_REQ = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ack;
    logic [31:0] i_imem_rdata;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        i_stall;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic        o_valid;
    logic        o_fetch_fault;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_ack    (i_imem_ack),
        .i_imem_rdata  (i_imem_rdata),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .i_stall       (i_stall),
        .o_instr       (o_instr),
        .o_pc          (o_pc),
        .o_valid       (o_valid),
        .o_fetch_fault (o_fetch_fault)
    );

    exp_t        sb[$];
    int          n_total = 0;
    int          n_bad   = 0;
    int          lat     = 1;
    int          mem_cnt = 0;
    int          ack_count = 0;
    int          pop_count = 0;
    int          snap;
    bit          mem_busy = 0, mem_drop = 0, mem_abandon = 0, stray_ack = 0;
    bit          ack_prev = 0, redir_prev = 0, redir_mis = 0, rst_applied = 0, chk_lat = 0;
    bit          found;
    logic [31:0] mem_addr = '0;
    logic [31:0] exp_req_addr = '0;

    function automatic logic [31:0] b2w(input logic x);
        return {31'b0, x};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: observe at negedge, then advance memory model just after posedge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (rst_applied) begin
            sb.delete();
            exp_req_addr = 32'h0;
            if (mem_busy) begin
                mem_drop    = 1;
                mem_abandon = 1;
            end
            if (!rst_n) begin
                chk("rst_req",   b2w(o_imem_req), 32'h0);
                chk("rst_addr",  o_imem_addr, 32'h0);
                chk("rst_valid", b2w(o_valid), 32'h0);
                chk("rst_instr", o_instr, c_NOP_INSTR);
                chk("rst_pc",    o_pc, 32'h0);
                chk("rst_fault", b2w(o_fetch_fault), 32'h0);
            end
        end
        if (chk_lat && ack_prev) chk("ack_to_valid", b2w(o_valid), 32'h1);
        if (redir_prev) chk("redir_next_valid", b2w(o_valid), b2w(redir_mis));
        if (o_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_valid", b2w(o_valid), 32'h0);
            end else begin
                e = sb[0];
                chk("out_pc",    o_pc, e.pc);
                chk("out_instr", o_instr, e.instr);
                chk("out_fault", b2w(o_fetch_fault), b2w(e.fault));
                if (!i_stall && !i_redirect) begin
                    void'(sb.pop_front());
                    pop_count++;
                end
            end
        end else begin
            chk("idle_instr", o_instr, c_NOP_INSTR);
        end
        if (mem_busy) begin
            if (!mem_abandon) begin
                chk("req_hold",  b2w(o_imem_req), 32'h1);
                chk("addr_hold", o_imem_addr, mem_addr);
            end
        end else if (o_imem_req) begin
            chk("req_addr", o_imem_addr, exp_req_addr);
            mem_busy    = 1;
            mem_addr    = o_imem_addr;
            mem_cnt     = lat;
            mem_drop    = 0;
            mem_abandon = 0;
        end
        if (i_redirect) begin
            sb.delete();
            if (mem_busy) mem_drop = 1;
            if (i_redirect_pc[1:0] != 2'b00) begin
                sb.push_back('{pc: i_redirect_pc, instr: c_NOP_INSTR, fault: 1'b1});
                exp_req_addr = c_NO_REQ;
            end else begin
                exp_req_addr = i_redirect_pc;
            end
        end
        @(posedge clk);
        #1;
        rst_applied = !rst_n;
        redir_prev  = i_redirect;
        redir_mis   = (i_redirect_pc[1:0] != 2'b00);
        ack_prev    = 0;
        if (i_imem_ack) begin
            i_imem_ack = 1'b0;
            if (mem_busy) begin
                if (!mem_drop) begin
                    sb.push_back('{pc: mem_addr, instr: mem_addr ^ c_KEY, fault: 1'b0});
                    exp_req_addr = mem_addr + 32'd4;
                    ack_prev = 1;
                    ack_count++;
                end
                mem_busy = 0;
            end
        end else if (stray_ack) begin
            stray_ack    = 0;
            i_imem_ack   = 1'b1;
            i_imem_rdata = 32'hDEAD_BEEF;
        end else if (mem_busy) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                i_imem_ack   = 1'b1;
                i_imem_rdata = mem_addr ^ c_KEY;
            end
        end
    endtask

    task automatic do_reset(input int cycles);
        int k;
        rst_n = 1'b0;
        k = 0;
        while ((k < cycles || mem_busy) && k < 20) begin
            tick();
            k++;
        end
        if (mem_busy) chk("reset_mem_timeout", 32'h1, 32'h0);
        rst_n = 1'b1;
    endtask

    task automatic redirect(input logic [31:0] target);
        i_redirect    = 1'b1;
        i_redirect_pc = target;
        tick();
        i_redirect    = 1'b0;
    endtask

    task automatic wait_first_wait_cycle(input string tag);
        found = 0;
        for (int k = 0; k < 30 && !found; k++) begin
            tick();
            if (mem_busy && !mem_drop && !i_imem_ack && mem_cnt == lat - 1) found = 1;
        end
        if (!found) chk(tag, 32'h0, 32'h1);
    endtask

    initial begin
        rst_n = 1'b0; i_imem_ack = 1'b0; i_imem_rdata = '0;
        i_redirect = 1'b0; i_redirect_pc = '0; i_stall = 1'b0;
        repeat (3) tick();

        // Streaming with 1-cycle memory, no stall
        rst_n = 1'b1;
        chk_lat = 1;
        repeat (30) tick();
        chk_lat = 0;
        chk("stream_progress", b2w(pop_count >= 12), 32'h1);

        // Stall from reset: buffer fills with two entries then requests stop
        do_reset(2);
        i_stall = 1'b1;
        snap = ack_count;
        repeat (10) tick();
        chk("stall_acks",      ack_count - snap, 32'd2);
        chk("stall_req_full",  b2w(o_imem_req), 32'h0);
        chk("stall_head_pc",   o_pc, 32'h0);
        chk("stall_head_valid", b2w(o_valid), 32'h1);
        i_stall = 1'b0;
        snap = pop_count;
        repeat (12) tick();
        chk("stall_drain", b2w(pop_count - snap >= 3), 32'h1);

        // Redirect during the first wait cycle of a 3-cycle request
        lat = 3;
        wait_first_wait_cycle("wait_timeout_t3");
        redirect(32'h0000_0100);
        snap = pop_count;
        repeat (24) tick();
        chk("redir100_progress", b2w(pop_count > snap), 32'h1);

        // Redirect coinciding with an ack
        lat = 2;
        found = 0;
        for (int k = 0; k < 30 && !found; k++) begin
            tick();
            if (i_imem_ack && mem_busy && !mem_drop) found = 1;
        end
        if (!found) chk("ack_timeout_t4", 32'h0, 32'h1);
        redirect(32'h0000_0200);
        snap = pop_count;
        repeat (16) tick();
        chk("redir200_progress", b2w(pop_count > snap), 32'h1);

        // Misaligned target: single fault entry, fetch halts, stray ack ignored
        lat = 1;
        repeat (3) tick();
        redirect(32'h0000_0202);
        repeat (5) tick();
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("fault_no_req", b2w(o_imem_req), 32'h0);
        end
        stray_ack = 1;
        repeat (3) tick();
        chk("fault_stray_valid", b2w(o_valid), 32'h0);
        redirect(32'h0000_0300);
        snap = pop_count;
        repeat (16) tick();
        chk("redir300_progress", b2w(pop_count > snap), 32'h1);

        // PC wrap at the top of the address space
        redirect(32'hFFFF_FFFC);
        snap = pop_count;
        repeat (12) tick();
        chk("wrap_progress", b2w(pop_count - snap >= 3), 32'h1);

        // Reset while a request is outstanding; its late ack must vanish
        lat = 3;
        wait_first_wait_cycle("wait_timeout_rst");
        do_reset(1);
        snap = pop_count;
        repeat (14) tick();
        chk("post_reset_progress", b2w(pop_count > snap), 32'h1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
